// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder definitions: word-width helpers used by both node units.
package ldpc_pkg;

  localparam int DATA_W_DEFAULT = 8;

  // Number of bits needed to represent x (log2(3)=2, log2(4)=3).
  function automatic int log2(input int x);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if (x >= (32'sd1 <<< i)) n = i + 1;
    end
    return n;
  endfunction

  // Largest magnitude emitted on a w-bit message bus (symmetric range).
  function automatic int SAT_MAX(input int w);
    return (32'sd1 <<< (w - 1)) - 32'sd1;
  endfunction

endpackage

// File: rtl/vnu_sat.sv
// Symmetric saturation: clips a wide signed value to +/-(2^(out_w-1)-1).
module vnu_sat
  import ldpc_pkg::*;
#(
  parameter int in_w  = 10,
  parameter int out_w = 8
) (
  input  logic signed [in_w-1:0]  din,
  output logic signed [out_w-1:0] dout
);

  localparam logic signed [in_w-1:0] max_c = in_w'(SAT_MAX(out_w));
  localparam logic signed [in_w-1:0] min_c = -max_c;

  // Clip against both rails; the most negative code is never produced.
  always_comb begin
    dout = din[out_w-1:0];
    if (din > max_c) begin
      dout = max_c[out_w-1:0];
    end else if (din < min_c) begin
      dout = min_c[out_w-1:0];
    end else begin
      dout = din[out_w-1:0];
    end
  end

endmodule

// File: rtl/vnu.sv
// Variable node unit: two-stage min-sum VNU producing extrinsic q messages and a hard decision.
module vnu
  import ldpc_pkg::*;
#(
  parameter int D      = 3,
  parameter int data_w = DATA_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [data_w-1:0]     llr,
  input  logic [data_w*D-1:0]   r,
  output logic [data_w*D-1:0]   q,
  output logic                  hard,
  output logic                  out_valid
);

  localparam int sum_w = data_w + log2(D);

  logic signed [sum_w-1:0]  r_ext_s [D];
  logic signed [sum_w-1:0]  sum_s;
  logic signed [sum_w-1:0]  r_ext_r [D];
  logic signed [sum_w-1:0]  total_r;
  logic                     v1_r;
  logic signed [sum_w-1:0]  e_s [D];
  logic signed [data_w-1:0] q_sat_s [D];
  logic [data_w*D-1:0]      q_r;
  logic                     hard_r;
  logic                     out_valid_r;

  // Sign-extend inputs and form the full-width node total (cannot overflow at sum_w).
  always_comb begin
    sum_s = {{(sum_w-data_w){llr[data_w-1]}}, llr};
    for (int i = 0; i < D; i++) begin
      r_ext_s[i] = {{(sum_w-data_w){r[i*data_w+data_w-1]}}, r[i*data_w +: data_w]};
      sum_s      = sum_s + r_ext_s[i];
    end
  end

  // Stage 1 registers: extended r words, total and valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) r_ext_r[i] <= '0;
      total_r <= '0;
      v1_r    <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < D; i++) r_ext_r[i] <= r_ext_s[i];
      total_r <= sum_s;
      v1_r    <= in_valid;
    end
  end

  // Extrinsic value excludes the message's own contribution.
  always_comb begin
    for (int i = 0; i < D; i++) begin
      e_s[i] = total_r - r_ext_r[i];
    end
  end

  for (genvar g = 0; g < D; g++) begin : g_sat
    vnu_sat #(.in_w(sum_w), .out_w(data_w)) u_sat (
      .din  (e_s[g]),
      .dout (q_sat_s[g])
    );
  end

  // Stage 2 registers: clipped q words, hard decision and output valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r         <= '0;
      hard_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < D; i++) q_r[i*data_w +: data_w] <= q_sat_s[i];
      hard_r      <= total_r[sum_w-1];
      out_valid_r <= v1_r;
    end
  end

  assign q         = q_r;
  assign hard      = hard_r;
  assign out_valid = out_valid_r;

endmodule
